key_rate_ctrl: RTL

- Consumer side of the debounced-key interface: takes the stable, idle-high key status lines (pause, speed-up, speed-down) and turns presses into run/pause state and a speed level.
- Produces a single-cycle rate tick and a wrapping step index that drive the Lab1 display/sequencer.
- Sits directly downstream of the key debouncer; all inputs are already stable and synchronous to clk.

---
 rtl/key_rate_ctrl_if.sv | 24 ++
 rtl/key_rate_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/key_rate_ctrl_if.sv
// Key/rate bundle between the key debouncer side and key_rate_ctrl.
// master: drives the debounced key status lines and watches the rate outputs.
// slave : the rate controller itself.
interface key_rate_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic             pause_status;
  logic             spdup_status;
  logic             spddn_status;
  logic             running;
  logic [1:0]       level;
  logic             tick;
  logic [IDX_W-1:0] step_idx;

  modport master (
    output pause_status, spdup_status, spddn_status,
    input  running, level, tick, step_idx
  );

  modport slave (
    input  pause_status, spdup_status, spddn_status,
    output running, level, tick, step_idx
  );
endinterface

// File: rtl/key_rate_ctrl.sv
// key_rate_ctrl: turns debounced idle-high key presses into run/pause state
// and a 4-step speed level, and emits a one-cycle rate tick plus a wrapping
// step index. Tick period is TICK_BASE >> level clk cycles.
module key_rate_ctrl #(
  parameter int unsigned TICK_BASE   = 25_000_000,
  parameter int unsigned RESET_LEVEL = 1,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned IDX_W       = 4
) (
  input logic            clk,
  input logic            reset,
  key_rate_ctrl_if.slave bus
);
  localparam logic [31:0]      C_TICK_BASE   = 32'(TICK_BASE);
  localparam logic [1:0]       C_RESET_LEVEL = 2'(RESET_LEVEL);
  localparam logic [IDX_W-1:0] C_IDX_LAST    = IDX_W'(DEPTH - 1);

  // key bit order: 0 = pause, 1 = speed-up, 2 = speed-down
  logic [2:0]       w_keys;
  logic [2:0]       r_prev;
  logic [2:0]       w_press;
  logic             r_armed;
  logic             r_running;
  logic [1:0]       r_level;
  logic             r_tick;
  logic [IDX_W-1:0] r_step_idx;
  logic [31:0]      r_cnt;

  logic             w_pause_press;
  logic             w_up_press;
  logic             w_dn_press;
  logic [1:0]       w_level_next;
  logic             w_level_change;
  logic [31:0]      w_period;
  logic             w_terminal;

  assign w_keys = {bus.spddn_status, bus.spdup_status, bus.pause_status};

  // A press is a registered 1->0 edge. r_armed masks the first cycle after
  // reset so a key held low through reset is not seen as a fresh press.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      assign w_press[gi] = r_armed & r_prev[gi] & ~w_keys[gi];
    end
  endgenerate

  assign w_pause_press = w_press[0];
  assign w_up_press    = w_press[1];
  assign w_dn_press    = w_press[2];

  // Saturating level update; opposing presses in one cycle cancel out.
  always_comb begin
    w_level_next = r_level;
    if (w_up_press && !w_dn_press && r_level != 2'd3) begin
      w_level_next = r_level + 2'd1;
    end else if (w_dn_press && !w_up_press && r_level != 2'd0) begin
      w_level_next = r_level - 2'd1;
    end
  end

  assign w_level_change = (w_level_next != r_level);
  assign w_period       = C_TICK_BASE >> r_level;
  assign w_terminal     = (r_cnt == w_period - 32'd1);

  // Run/pause, level, period counter, tick and step index.
  // Priority: reset > pause toggle > level change > terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= 3'b111;
      r_armed    <= 1'b0;
      r_running  <= 1'b1;
      r_level    <= C_RESET_LEVEL;
      r_tick     <= 1'b0;
      r_step_idx <= '0;
      r_cnt      <= 32'd0;
    end else begin
      r_prev  <= w_keys;
      r_armed <= 1'b1;
      r_level <= w_level_next;
      r_tick  <= 1'b0;
      if (w_pause_press) begin
        // counter holds across a toggle so a paused phase resumes in place
        r_running <= ~r_running;
        if (w_level_change) begin
          r_cnt <= 32'd0;
        end
      end else if (w_level_change) begin
        // new period takes effect next cycle with a fresh phase
        r_cnt <= 32'd0;
      end else if (r_running) begin
        if (w_terminal) begin
          r_cnt      <= 32'd0;
          r_tick     <= 1'b1;
          r_step_idx <= (r_step_idx == C_IDX_LAST) ? '0 : r_step_idx + IDX_W'(1);
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
    end
  end

  assign bus.running  = r_running;
  assign bus.level    = r_level;
  assign bus.tick     = r_tick;
  assign bus.step_idx = r_step_idx;
endmodule
